// File: rtl/lut_arbiter_if.sv
// Request/response bundle between requesters and the shared lookup table.
// master drives requests and rsp_ready; slave (the arbiter) drives grants and responses.
interface lut_arbiter_if #(
    parameter int NR_REQ   = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8
);
    localparam int ID_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]         req_valid;
    logic [NR_REQ*KEY_LEN-1:0] req_key;
    logic [NR_REQ-1:0]         req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_LEN-1:0]       rsp_data;
    logic                      rsp_hit;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit
    );
endinterface

// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one small key/data lookup table among NR_REQ requesters.
// Latency: grant at cycle T, rsp_valid at T+2; at most one lookup in flight (one per 3 cycles).
// Backpressure: response held in RESP until rsp_ready; no grants until then. LUT_ARBITER_STATS_EN adds hit/miss counters.
module lut_arbiter #(
    parameter int NR_REQ      = 4,
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 1,
    localparam int ID_W       = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
    localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [KEY_LEN-1:0]  cfg_key,
    input  logic [DATA_LEN-1:0] cfg_data,
    input  logic                cfg_en,
    input  logic [DATA_LEN-1:0] default_out,
    lut_arbiter_if.slave        bus,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant;
    logic                grant_vld;
    logic [ID_W-1:0]     id_q;
    logic [KEY_LEN-1:0]  key_q;

    logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
    logic [DATA_LEN-1:0] tbl_data [NR_KEY];
    logic [NR_KEY-1:0]   tbl_vld;

    logic                lookup_hit;
    logic [DATA_LEN-1:0] lookup_data;
    logic [DATA_LEN-1:0] miss_data;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NR_REQ;
            if (bus.req_valid[idx]) begin
                grant     = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_vld && rst_n) begin
                    bus.req_ready[grant] = 1'b1;
                    state_nxt            = LOOKUP;
                end
            end
            LOOKUP:  state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int e = 0; e < NR_KEY; e++) begin
            if (tbl_vld[e] && (tbl_key[e] == key_q)) begin
                lookup_hit  = 1'b1;
                lookup_data = lookup_data | tbl_data[e];
            end
        end
    end

    assign miss_data = (HAS_DEFAULT != 0) ? default_out : '0;

    // Key/data storage carries no reset: the valid bits alone gate matching.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_key[cfg_idx]  <= cfg_key;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            tbl_vld      <= '0;
            key_q        <= '0;
            id_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_hit  <= 1'b0;
            bus.rsp_id   <= '0;
        end else begin
            if (cfg_we) begin
                tbl_vld[cfg_idx] <= cfg_en;
            end
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        key_q  <= bus.req_key[grant*KEY_LEN +: KEY_LEN];
                        id_q   <= grant;
                        rr_ptr <= (grant == ID_W'(NR_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                LOOKUP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= lookup_hit ? lookup_data : miss_data;
                    bus.rsp_hit   <= lookup_hit;
                    bus.rsp_id    <= id_q;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LUT_ARBITER_STATS_EN
    logic [15:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (lookup_hit) begin
                if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
                if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed and randomized bench for lut_arbiter against a table/round-robin reference model.
module tb_lut_arbiter;
    localparam int NR_REQ      = 4;
    localparam int NR_KEY      = 8;
    localparam int KEY_LEN     = 4;
    localparam int DATA_LEN    = 8;
    localparam int HAS_DEFAULT = 1;
    localparam int IDX_W       = $clog2(NR_KEY);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [KEY_LEN-1:0]  cfg_key;
    logic [DATA_LEN-1:0] cfg_data;
    logic                cfg_en;
    logic [DATA_LEN-1:0] default_out;
    logic [15:0]         hit_cnt, miss_cnt;

    lut_arbiter_if #(.NR_REQ(NR_REQ), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) bus ();

    lut_arbiter #(
        .NR_REQ(NR_REQ), .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN),
        .DATA_LEN(DATA_LEN), .HAS_DEFAULT(HAS_DEFAULT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_key(cfg_key), .cfg_data(cfg_data), .cfg_en(cfg_en),
        .default_out(default_out), .bus(bus),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [KEY_LEN-1:0]  m_key  [NR_KEY];
    logic [DATA_LEN-1:0] m_data [NR_KEY];
    bit                  m_vld  [NR_KEY];
    int                  m_ptr;
    int                  m_hits, m_miss;

    int                  w_idx;
    logic [KEY_LEN-1:0]  w_key;
    logic [DATA_LEN-1:0] w_data;
    bit                  w_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR_KEY; i++) m_vld[i] = 1'b0;
        m_ptr  = 0;
        m_hits = 0;
        m_miss = 0;
    endfunction

    function automatic int model_grant(input logic [NR_REQ-1:0] rv);
        for (int k = 0; k < NR_REQ; k++)
            if (rv[(m_ptr + k) % NR_REQ]) return (m_ptr + k) % NR_REQ;
        return -1;
    endfunction

    function automatic void model_lookup(input logic [KEY_LEN-1:0] k,
                                         output logic [DATA_LEN-1:0] d, output bit h);
        d = '0;
        h = 1'b0;
        for (int i = 0; i < NR_KEY; i++)
            if (m_vld[i] && m_key[i] == k) begin
                h = 1'b1;
                d = d | m_data[i];
            end
        if (!h) d = (HAS_DEFAULT != 0) ? default_out : '0;
        if (h) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
        else   m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
    endfunction

    function automatic int exp_hits();
`ifdef LUT_ARBITER_STATS_EN
        return m_hits;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_miss();
`ifdef LUT_ARBITER_STATS_EN
        return m_miss;
`else
        return 0;
`endif
    endfunction

    task automatic set_cfg(input int idx, input logic [KEY_LEN-1:0] k,
                           input logic [DATA_LEN-1:0] d, input bit en);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'(idx);
        cfg_key  = k;
        cfg_data = d;
        cfg_en   = en;
        m_key[idx]  = k;
        m_data[idx] = d;
        m_vld[idx]  = en;
    endtask

    task automatic cfg_write(input int idx, input logic [KEY_LEN-1:0] k,
                             input logic [DATA_LEN-1:0] d, input bit en);
        @(negedge clk);
        set_cfg(idx, k, d, en);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [NR_REQ*KEY_LEN-1:0] one_key(input int req, input logic [KEY_LEN-1:0] k);
        logic [NR_REQ*KEY_LEN-1:0] v;
        v = '0;
        v[req*KEY_LEN +: KEY_LEN] = k;
        return v;
    endfunction

    // One full request/response; optional cfg writes during LOOKUP/RESP, stalls, or reset in RESP.
    task automatic transact(input logic [NR_REQ-1:0] rv, input logic [NR_REQ*KEY_LEN-1:0] keys,
                            input int stall, input bit wl, input bit wr, input bit rst_resp);
        int                  g;
        logic [DATA_LEN-1:0] ed;
        bit                  eh;
        @(negedge clk);
        #1;
        chk("idle_no_grant", bus.req_ready, 0);
        bus.req_valid = rv;
        bus.req_key   = keys;
        #1;
        g = model_grant(rv);
        chk("grant_onehot", bus.req_ready, 32'd1 << g);
        m_ptr = (g + 1) % NR_REQ;
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        model_lookup(keys[g*KEY_LEN +: KEY_LEN], ed, eh);
        if (wl) set_cfg(w_idx, w_key, w_data, w_en);
        #1;
        chk("lookup_ready_low", bus.req_ready, 0);
        chk("lookup_no_rsp", bus.rsp_valid, 0);
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            bus.req_valid = NR_REQ'($urandom_range(0, (1 << NR_REQ) - 1));
            bus.rsp_ready = (s == stall);
            if (wr && s == 0) set_cfg(w_idx, w_key, w_data, w_en);
            #1;
            chk("resp_valid", bus.rsp_valid, 1);
            chk("resp_id", bus.rsp_id, g);
            chk("resp_data", bus.rsp_data, ed);
            chk("resp_hit", bus.rsp_hit, eh);
            chk("resp_ready_low", bus.req_ready, 0);
            if (rst_resp) begin
                rst_n = 1'b0;
                bus.req_valid = '0;
                @(negedge clk);
                cfg_we = 1'b0;
                model_reset();
                chk("rst_resp_valid", bus.rsp_valid, 0);
                chk("rst_hit_cnt", hit_cnt, 0);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        cfg_we = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        chk("released", bus.rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0; cfg_en = 1'b0;
        default_out = 8'h3C;
        bus.req_valid = '0; bus.req_key = '0; bus.rsp_ready = 1'b0;
        model_reset();

        // reset state, sampled while reset is still applied
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_hit", bus.rsp_hit, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;

        // key 0 against reset (invalid) entries misses
        transact(4'b0001, one_key(0, 4'h0), 0, 0, 0, 0);
        // basic hit, requester 1
        cfg_write(2, 4'h5, 8'hA5, 1'b1);
        transact(4'b0010, one_key(1, 4'h5), 0, 0, 0, 0);
        // miss returns default
        transact(4'b0001, one_key(0, 4'h7), 0, 0, 0, 0);

        // counters: 3 hits and 2 misses from a clean reset
        do_reset();
        cfg_write(2, 4'h5, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) transact(4'b0100, one_key(2, 4'h5), 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) transact(4'b1000, one_key(3, 4'h9), 0, 0, 0, 0);
        chk("hit_cnt_3", hit_cnt, exp_hits());
        chk("miss_cnt_2", miss_cnt, exp_miss());

        // all requesters held valid: grants 0,1,2,3,0 three cycles apart
        do_reset();
        @(negedge clk);
        bus.req_valid = '1;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            logic [DATA_LEN-1:0] ed;
            bit eh;
            #1;
            chk("rr_grant", bus.req_ready, 32'd1 << (n % NR_REQ));
            m_ptr = (n + 1) % NR_REQ;
            model_lookup(4'h0, ed, eh);
            @(negedge clk); #1;
            chk("rr_gap1", bus.req_ready, 0);
            @(negedge clk); #1;
            chk("rr_gap2", bus.req_ready, 0);
            chk("rr_rsp_id", bus.rsp_id, n % NR_REQ);
            chk("rr_rsp_data", bus.rsp_data, ed);
            @(negedge clk);
            if (n == 4) begin
                bus.req_valid = '0;
                bus.rsp_ready = 1'b0;
            end
        end

        // stall 5 cycles in RESP with a write to the matched entry
        cfg_write(2, 4'h5, 8'hA5, 1'b1);
        w_idx = 2; w_key = 4'h5; w_data = 8'h5A; w_en = 1'b1;
        transact(4'b0001, one_key(0, 4'h5), 5, 0, 1, 0);
        transact(4'b0001, one_key(0, 4'h5), 0, 0, 0, 0);

        // duplicate keys OR together; reset during RESP abandons and invalidates
        cfg_write(0, 4'h1, 8'h0F, 1'b1);
        cfg_write(3, 4'h1, 8'hF0, 1'b1);
        transact(4'b0001, one_key(0, 4'h1), 0, 0, 0, 0);
        transact(4'b0001, one_key(0, 4'h1), 0, 0, 0, 1);
        transact(4'b0001, one_key(0, 4'h1), 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < NR_KEY; i++)
            cfg_write(i, KEY_LEN'($urandom_range(0, 7)), DATA_LEN'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int t = 0; t < 40; t++) begin
            logic [NR_REQ*KEY_LEN-1:0] keys;
            for (int r = 0; r < NR_REQ; r++) keys[r*KEY_LEN +: KEY_LEN] = KEY_LEN'($urandom_range(0, 7));
            default_out = DATA_LEN'($urandom);
            w_idx  = $urandom_range(0, NR_KEY - 1);
            w_key  = KEY_LEN'($urandom_range(0, 7));
            w_data = DATA_LEN'($urandom);
            w_en   = 1'($urandom_range(0, 3) != 0);
            transact(NR_REQ'($urandom_range(1, (1 << NR_REQ) - 1)), keys,
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("final_hit_cnt", hit_cnt, exp_hits());
        chk("final_miss_cnt", miss_cnt, exp_miss());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
